// File: rtl/board_pkg.sv
// Shared constants and types for the game-board RAM arbiter.
package board_pkg;

  localparam int unsigned NUM_REQ      = 4;
  localparam int unsigned REQ_IDX_W    = 2;
  localparam int unsigned BOARD_ADDR_W = 6;
  localparam int unsigned PIECE_W      = 4;

  localparam int unsigned REQ_CONTROL   = 0;
  localparam int unsigned REQ_VALIDATOR = 1;
  localparam int unsigned REQ_DATAPATH  = 2;
  localparam int unsigned REQ_VIEW      = 3;

  localparam logic [NUM_REQ-1:0] DEFAULT_WRITER_MASK = NUM_REQ'(1) << REQ_DATAPATH;

  // One entry of the read-return tracking pipeline.
  typedef struct packed {
    logic                 valid;
    logic [REQ_IDX_W-1:0] tag;
  } rd_tag_t;

  function automatic logic [REQ_IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [REQ_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (oh[i]) idx = REQ_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/board_arbiter_rr_pick.sv
// Combinational 4-way round-robin picker; searches upward from last_grant+1.
module rr_pick
  import board_pkg::*;
(
  input  logic [NUM_REQ-1:0]   req,
  input  logic [REQ_IDX_W-1:0] last_grant,
  input  logic [NUM_REQ-1:0]   exclude,
  output logic [NUM_REQ-1:0]   gnt
);

  logic [NUM_REQ-1:0]   elig;
  logic [REQ_IDX_W-1:0] idx;

  assign elig = req & ~exclude;

  // Walk from lowest to highest priority so the nearest eligible requester wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = int'(NUM_REQ); i >= 1; i--) begin
      idx = last_grant + REQ_IDX_W'(i);
      if (elig[idx]) gnt = NUM_REQ'(1) << idx;
    end
  end

endmodule

// File: rtl/board_arbiter.sv
// Round-robin arbiter with bounded lock sharing the single-port board RAM;
// returns tagged read data to the requester that issued each read.
module board_arbiter
  import board_pkg::*;
#(
  parameter int unsigned        ADDR_W       = BOARD_ADDR_W,
  parameter int unsigned        DATA_W       = PIECE_W,
  parameter int unsigned        READ_LATENCY = 1,
  parameter logic [NUM_REQ-1:0] WRITER_MASK  = DEFAULT_WRITER_MASK,
  parameter int unsigned        MAX_LOCK     = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [NUM_REQ*DATA_W-1:0] rdata,
  output logic [NUM_REQ-1:0]        wr_err,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_we,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int unsigned      CNT_W    = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] LOCK_CAP = CNT_W'(MAX_LOCK);

  localparam logic [0:0] LOCK_IDLE = 1'b0;
  localparam logic [0:0] LOCK_HELD = 1'b1;

  logic [0:0]           lock_state, lock_state_n;
  logic [REQ_IDX_W-1:0] lock_owner, lock_owner_n;
  logic [CNT_W-1:0]     lock_cnt, lock_cnt_n;
  logic [REQ_IDX_W-1:0] last_grant, last_grant_n;
  rd_tag_t              tag_pipe [READ_LATENCY];
  rd_tag_t              push_tag;
  rd_tag_t              tail;
  logic [NUM_REQ-1:0]   wr_err_n;

  logic [NUM_REQ-1:0]   owner_oh;
  logic                 held;
  logic                 contended;
  logic                 at_cap;
  logic                 keep;
  logic [NUM_REQ-1:0]   exclude;
  logic [NUM_REQ-1:0]   rr_gnt;
  logic [REQ_IDX_W-1:0] g_idx;

  // Lock holds while the owner keeps req+lock, unless capped with someone else waiting.
  always_comb begin
    owner_oh  = NUM_REQ'(1) << lock_owner;
    held      = (lock_state == LOCK_HELD) && req[lock_owner] && lock[lock_owner];
    contended = |(req & ~owner_oh);
    at_cap    = (lock_cnt == LOCK_CAP);
    keep      = held && !(at_cap && contended);
    exclude   = (held && at_cap && contended) ? owner_oh : '0;
  end

  rr_pick u_rr_pick (
    .req        (req),
    .last_grant (last_grant),
    .exclude    (exclude),
    .gnt        (rr_gnt)
  );

  // Grant, RAM access and next-state for lock, rotation and read tracking.
  always_comb begin
    gnt          = '0;
    g_idx        = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_we       = 1'b0;
    wr_err_n     = '0;
    push_tag     = '0;
    last_grant_n = last_grant;
    lock_state_n = LOCK_IDLE;
    lock_owner_n = lock_owner;
    lock_cnt_n   = '0;

    if (resetn) gnt = keep ? owner_oh : rr_gnt;
    g_idx = onehot_to_idx(gnt);

    if (|gnt) begin
      mem_addr       = req_addr[ADDR_W*g_idx +: ADDR_W];
      mem_wdata      = req_wdata[DATA_W*g_idx +: DATA_W];
      mem_we         = req_we[g_idx] & WRITER_MASK[g_idx];
      wr_err_n       = (req_we[g_idx] & ~WRITER_MASK[g_idx]) ? gnt : '0;
      // Disallowed writes are executed as reads, so they still get a return.
      push_tag.valid = ~mem_we;
      push_tag.tag   = g_idx;
      last_grant_n   = g_idx;
      if (keep) begin
        lock_state_n = LOCK_HELD;
        lock_cnt_n   = at_cap ? lock_cnt : lock_cnt + CNT_W'(1);
      end else if (lock[g_idx]) begin
        lock_state_n = LOCK_HELD;
        lock_owner_n = g_idx;
        lock_cnt_n   = CNT_W'(1);
      end
    end
  end

  assign tail = tag_pipe[READ_LATENCY-1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_state <= LOCK_IDLE;
      lock_owner <= '0;
      lock_cnt   <= '0;
      last_grant <= REQ_IDX_W'(NUM_REQ - 1);
      rvalid     <= '0;
      wr_err     <= '0;
      rdata      <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      lock_state  <= lock_state_n;
      lock_owner  <= lock_owner_n;
      lock_cnt    <= lock_cnt_n;
      last_grant  <= last_grant_n;
      wr_err      <= wr_err_n;
      tag_pipe[0] <= push_tag;
      for (int unsigned i = 1; i < READ_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
      rvalid      <= tail.valid ? (NUM_REQ'(1) << tail.tag) : '0;
      if (tail.valid) rdata[DATA_W*tail.tag +: DATA_W] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_board_arbiter.sv
// Randomized self-checking bench for board_arbiter at read latencies 1 and 3
// against a cycle-level reference model of the arbitration and read-return rules.
module tb_board_arbiter;

  localparam int          MAXL  = 8;
  localparam logic [3:0]  WMASK = 4'b0100;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  req, lock, req_we;
  logic [23:0] req_addr;
  logic [15:0] req_wdata;

  logic [3:0]  gnt_a, rvalid_a, wr_err_a, mem_wdata_a, mem_rdata_a;
  logic [15:0] rdata_a;
  logic [5:0]  mem_addr_a;
  logic        mem_we_a;
  logic [3:0]  gnt_b, rvalid_b, wr_err_b, mem_wdata_b, mem_rdata_b;
  logic [15:0] rdata_b;
  logic [5:0]  mem_addr_b;
  logic        mem_we_b;

  always #5 clk = ~clk;

  board_arbiter #(.ADDR_W(6), .DATA_W(4), .READ_LATENCY(1), .WRITER_MASK(WMASK), .MAX_LOCK(MAXL)) u_dut_a (
    .clk(clk), .resetn(resetn), .req(req), .lock(lock), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt_a), .rvalid(rvalid_a),
    .rdata(rdata_a), .wr_err(wr_err_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_we(mem_we_a), .mem_rdata(mem_rdata_a)
  );

  board_arbiter #(.ADDR_W(6), .DATA_W(4), .READ_LATENCY(3), .WRITER_MASK(WMASK), .MAX_LOCK(MAXL)) u_dut_b (
    .clk(clk), .resetn(resetn), .req(req), .lock(lock), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt_b), .rvalid(rvalid_b),
    .rdata(rdata_b), .wr_err(wr_err_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_we(mem_we_b), .mem_rdata(mem_rdata_b)
  );

  // Board RAM models: latency 1 for instance a, latency 3 for instance b.
  logic [3:0] ram_a [64];
  logic [3:0] ram_b [64];
  logic [3:0] pa;
  logic [3:0] pb [3];

  always @(posedge clk) begin
    if (mem_we_a) ram_a[mem_addr_a] <= mem_wdata_a;
    pa <= ram_a[mem_addr_a];
    if (mem_we_b) ram_b[mem_addr_b] <= mem_wdata_b;
    pb[0] <= ram_b[mem_addr_b];
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end

  assign mem_rdata_a = pa;
  assign mem_rdata_b = pb[2];

  // Reference model state.
  int          n_total = 0;
  int          n_bad   = 0;
  int          last_m, owner_m, cnt_m, edge_n;
  int          dec_g;
  bit          dec_locked;
  logic [3:0]  shadow [64];
  bit          slot_v [2][8];
  int          slot_t [2][8];
  logic [3:0]  slot_d [2][8];
  logic [3:0]  exp_rvalid [2];
  logic [15:0] exp_rdata [2];
  logic [3:0]  exp_wrerr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    last_m  = 3;
    owner_m = -1;
    cnt_m   = 0;
    exp_wrerr = '0;
    for (int k = 0; k < 2; k++) begin
      exp_rvalid[k] = '0;
      exp_rdata[k]  = '0;
      for (int s = 0; s < 8; s++) slot_v[k][s] = 1'b0;
    end
  endtask

  // Who gets the RAM this cycle, from the current inputs and model lock state.
  task automatic decide();
    bit others, owner_live;
    int excl, c;
    dec_g = -1;
    dec_locked = 1'b0;
    excl = -1;
    if (resetn && req != 4'b0) begin
      owner_live = (owner_m >= 0) && req[owner_m] && lock[owner_m];
      others = 1'b0;
      for (int k = 0; k < 4; k++) if (k != owner_m && req[k]) others = 1'b1;
      if (owner_live && !(cnt_m == MAXL && others)) begin
        dec_g = owner_m;
        dec_locked = 1'b1;
      end else begin
        if (owner_live) excl = owner_m;
        for (int k = 1; k <= 4; k++) begin
          c = (last_m + k) % 4;
          if (dec_g < 0 && req[c] && c != excl) dec_g = c;
        end
      end
    end
  endtask

  // Apply one clock edge to the model.
  task automatic commit();
    logic [5:0] a;
    logic [3:0] d;
    int s;
    edge_n++;
    if (!resetn) begin
      model_reset();
      return;
    end
    exp_wrerr = '0;
    if (dec_g >= 0) begin
      a = req_addr[dec_g*6 +: 6];
      d = req_wdata[dec_g*4 +: 4];
      if (req_we[dec_g] && WMASK[dec_g]) begin
        shadow[a] = d;
      end else begin
        if (req_we[dec_g]) exp_wrerr[dec_g] = 1'b1;
        s = (edge_n + 1) % 8;
        slot_v[0][s] = 1'b1; slot_t[0][s] = dec_g; slot_d[0][s] = shadow[a];
        s = (edge_n + 3) % 8;
        slot_v[1][s] = 1'b1; slot_t[1][s] = dec_g; slot_d[1][s] = shadow[a];
      end
      if (dec_locked) cnt_m = (cnt_m < MAXL) ? cnt_m + 1 : MAXL;
      else if (lock[dec_g]) begin owner_m = dec_g; cnt_m = 1; end
      else begin owner_m = -1; cnt_m = 0; end
      last_m = dec_g;
    end else begin
      owner_m = -1;
      cnt_m = 0;
    end
    s = edge_n % 8;
    for (int k = 0; k < 2; k++) begin
      exp_rvalid[k] = '0;
      if (slot_v[k][s]) begin
        exp_rvalid[k][slot_t[k][s]] = 1'b1;
        exp_rdata[k][slot_t[k][s]*4 +: 4] = slot_d[k][s];
        slot_v[k][s] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    logic [3:0] eg, ed;
    logic [5:0] ea;
    logic       ew;
    eg = '0; ed = '0; ea = '0; ew = 1'b0;
    if (dec_g >= 0) begin
      eg[dec_g] = 1'b1;
      ew = req_we[dec_g] & WMASK[dec_g];
      ea = req_addr[dec_g*6 +: 6];
      ed = req_wdata[dec_g*4 +: 4];
    end
    chk("a.gnt",       32'(gnt_a),       32'(eg));
    chk("a.mem_we",    32'(mem_we_a),    32'(ew));
    chk("a.mem_addr",  32'(mem_addr_a),  32'(ea));
    chk("a.mem_wdata", 32'(mem_wdata_a), 32'(ed));
    chk("a.rvalid",    32'(rvalid_a),    32'(exp_rvalid[0]));
    chk("a.rdata",     32'(rdata_a),     32'(exp_rdata[0]));
    chk("a.wr_err",    32'(wr_err_a),    32'(exp_wrerr));
    chk("b.gnt",       32'(gnt_b),       32'(eg));
    chk("b.mem_we",    32'(mem_we_b),    32'(ew));
    chk("b.mem_addr",  32'(mem_addr_b),  32'(ea));
    chk("b.mem_wdata", 32'(mem_wdata_b), 32'(ed));
    chk("b.rvalid",    32'(rvalid_b),    32'(exp_rvalid[1]));
    chk("b.rdata",     32'(rdata_b),     32'(exp_rdata[1]));
    chk("b.wr_err",    32'(wr_err_b),    32'(exp_wrerr));
  endtask

  // One clock cycle: check mid-cycle, then advance model past the edge.
  task automatic step();
    @(negedge clk);
    if (!resetn) model_reset();
    decide();
    check_all();
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic set_in(input logic [3:0] r, input logic [3:0] l, input logic [3:0] w);
    req = r;
    lock = l;
    req_we = w;
    for (int k = 0; k < 4; k++) begin
      req_addr[k*6 +: 6]  = 6'($urandom_range(0, 15));
      req_wdata[k*4 +: 4] = 4'($urandom);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(4'b0000, 4'b0000, 4'b0000);
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram_a[i] = '0; ram_b[i] = '0; shadow[i] = '0;
    end
    pa = '0;
    for (int i = 0; i < 3; i++) pb[i] = '0;
    edge_n = 0;
    model_reset();

    // Reset state, including requests held during reset.
    resetn = 1'b0;
    set_in(4'b0000, 4'b0000, 4'b0000);
    step();
    set_in(4'b1111, 4'b0000, 4'b0000);
    step();
    step();
    resetn = 1'b1;

    // All four reading: plain rotation starting at control.
    for (int i = 0; i < 5; i++) begin
      set_in(4'b1111, 4'b0000, 4'b0000);
      step();
    end
    idle(5);

    // Datapath write then validator read of the same address.
    set_in(4'b0100, 4'b0000, 4'b0100);
    req_addr[12 +: 6] = 6'd10;
    req_wdata[8 +: 4] = 4'hA;
    step();
    set_in(4'b0010, 4'b0000, 4'b0000);
    req_addr[6 +: 6] = 6'd10;
    step();
    idle(5);

    // View holds a lock against a waiting control requester.
    for (int i = 0; i < 20; i++) begin
      set_in(4'b1001, 4'b1000, 4'b0000);
      step();
    end
    idle(5);

    // Control attempts a write it is not allowed to make.
    set_in(4'b0001, 4'b0000, 4'b0001);
    req_addr[0 +: 6] = 6'd10;
    step();
    idle(5);

    // Alternating validator and view reads, back to back.
    for (int i = 0; i < 12; i++) begin
      set_in((i % 2 == 0) ? 4'b0010 : 4'b1000, 4'b0000, 4'b0000);
      step();
    end
    idle(5);

    // Randomized traffic with a bias toward view locking.
    for (int i = 0; i < 2000; i++) begin
      logic [3:0] r, l;
      r = 4'($urandom) | (($urandom_range(0, 2) == 0) ? 4'b1000 : 4'b0000);
      l = (4'($urandom) & 4'($urandom)) | (($urandom_range(0, 1) == 0) ? 4'b1000 : 4'b0000);
      set_in(r, l, 4'($urandom));
      for (int k = 0; k < 4; k++) req_addr[k*6 +: 6] = 6'($urandom_range(0, 7));
      step();
      if ($urandom_range(0, 40) == 0) idle(1);
    end
    idle(5);

    // Reset asserted with reads in flight.
    for (int i = 0; i < 3; i++) begin
      set_in(4'b1111, 4'b0000, 4'b0000);
      step();
    end
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
    set_in(4'b1111, 4'b0000, 4'b0000);
    step();
    idle(6);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
